// File: rtl/cpu_core_p.sv
// Multi-cycle load/store core: 16-bit instruction word, 8 x DW register file,
// single shared memory port with a req/ack handshake.
module cpu_core_p #(
    parameter int          DW       = 16,
    parameter int          AW       = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic          CLK,
    input  logic          reset,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          halted,
    output logic          illegal
);
    localparam int SHW = $clog2(DW);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_OR   = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_SL   = 5'd5;
    localparam logic [4:0] OP_SR   = 5'd6;
    localparam logic [4:0] OP_ADDI = 5'd7;
    localparam logic [4:0] OP_SUBI = 5'd8;
    localparam logic [4:0] OP_ORI  = 5'd9;
    localparam logic [4:0] OP_ANDI = 5'd10;
    localparam logic [4:0] OP_XORI = 5'd11;
    localparam logic [4:0] OP_SLI  = 5'd12;
    localparam logic [4:0] OP_SRI  = 5'd13;
    localparam logic [4:0] OP_GT   = 5'd14;
    localparam logic [4:0] OP_LT   = 5'd15;
    localparam logic [4:0] OP_EQ   = 5'd16;
    localparam logic [4:0] OP_BR   = 5'd17;
    localparam logic [4:0] OP_STW  = 5'd18;
    localparam logic [4:0] OP_LDW  = 5'd19;
    localparam logic [4:0] OP_BZ   = 5'd20;
    localparam logic [4:0] OP_BN   = 5'd21;
    localparam logic [4:0] OP_HALT = 5'd22;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   ir_q, ir_d;
    logic [DW-1:0] mdr_q, mdr_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [DW-1:0] res_q, res_d;
    logic          z_q, z_d;
    logic          n_q, n_d;
    logic          illegal_q, illegal_d;
    logic          run_q, run_d;

    logic [DW-1:0] rf_q [8];
    logic [DW-1:0] rf_d [8];
    logic          rf_we;
    logic [2:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;

    logic [4:0]    op;
    logic [2:0]    rd, ra, rb;
    logic [4:0]    imm5;
    logic [DW-1:0] imm_ext;
    logic [AW-1:0] pc_off;
    logic [2:0]    rport_b;
    logic          is_imm;
    logic [SHW-1:0] shamt;
    logic [DW-1:0] alu_res;
    logic          cmp_bit;

    assign op      = ir_q[15:11];
    assign rd      = ir_q[10:8];
    assign ra      = ir_q[7:5];
    assign rb      = ir_q[4:2];
    assign imm5    = ir_q[4:0];
    assign imm_ext = {{(DW-5){imm5[4]}}, imm5};
    assign pc_off  = {{(AW-5){imm5[4]}}, imm5};
    assign is_imm  = (op >= OP_ADDI) && (op <= OP_SRI);
    assign shamt   = b_q[SHW-1:0];
    // The second read port serves the store data register for STW.
    assign rport_b = (op == OP_STW) ? rd : rb;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rf
            assign rf_d[gi] = (rf_we && (rf_waddr == 3'(gi))) ? rf_wdata : rf_q[gi];
        end
    endgenerate

    always_comb begin
        cmp_bit = 1'b0;
        alu_res = '0;
        case (op)
            OP_ADD, OP_ADDI: alu_res = a_q + b_q;
            OP_SUB, OP_SUBI: alu_res = a_q - b_q;
            OP_OR,  OP_ORI:  alu_res = a_q | b_q;
            OP_AND, OP_ANDI: alu_res = a_q & b_q;
            OP_XOR, OP_XORI: alu_res = a_q ^ b_q;
            OP_SL,  OP_SLI:  alu_res = a_q << shamt;
            OP_SR,  OP_SRI:  alu_res = a_q >> shamt;
            OP_GT: begin
                cmp_bit = $signed(a_q) > $signed(b_q);
                alu_res = {{(DW-1){1'b0}}, cmp_bit};
            end
            OP_LT: begin
                cmp_bit = $signed(a_q) < $signed(b_q);
                alu_res = {{(DW-1){1'b0}}, cmp_bit};
            end
            OP_EQ: begin
                cmp_bit = (a_q == b_q);
                alu_res = {{(DW-1){1'b0}}, cmp_bit};
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        mdr_d     = mdr_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        z_d       = z_q;
        n_d       = n_q;
        illegal_d = illegal_q;
        run_d     = 1'b1;
        rf_we     = 1'b0;
        rf_waddr  = rd;
        rf_wdata  = res_q;
        case (state_q)
            S_FETCH: begin
                if (mem_req && mem_ack) begin
                    ir_d    = mem_rdata[15:0];
                    pc_d    = pc_q + AW'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rf_q[ra];
                b_d     = is_imm ? imm_ext : rf_q[rport_b];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (op <= OP_EQ) begin
                    res_d   = alu_res;
                    state_d = S_WB;
                end else begin
                    case (op)
                        OP_BR: begin
                            pc_d    = pc_q + pc_off;
                            state_d = S_FETCH;
                        end
                        OP_BZ: begin
                            if (z_q) pc_d = pc_q + pc_off;
                            state_d = S_FETCH;
                        end
                        OP_BN: begin
                            if (n_q) pc_d = pc_q + pc_off;
                            state_d = S_FETCH;
                        end
                        OP_STW, OP_LDW: state_d = S_MEM;
                        OP_HALT:        state_d = S_HALT;
                        default: begin
                            illegal_d = 1'b1;
                            state_d   = S_HALT;
                        end
                    endcase
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (op == OP_LDW) begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_we = 1'b1;
                // Loads bypass the flags; only ALU/compare results update Z and N.
                if (op == OP_LDW) begin
                    rf_wdata = mdr_q;
                end else begin
                    z_d = (res_q == '0);
                    n_d = res_q[DW-1];
                end
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            pc_q      <= AW'(RESET_PC);
            ir_q      <= '0;
            mdr_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            z_q       <= 1'b0;
            n_q       <= 1'b0;
            illegal_q <= 1'b0;
            run_q     <= 1'b0;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            z_q       <= z_d;
            n_q       <= n_d;
            illegal_q <= illegal_d;
            run_q     <= run_d;
            for (int i = 0; i < 8; i++) rf_q[i] <= rf_d[i];
        end
    end

    // run_q keeps the first fetch off the bus until one clock edge after reset release.
    assign mem_req   = ((state_q == S_FETCH) && run_q) || (state_q == S_MEM);
    assign mem_we    = (state_q == S_MEM) && (op == OP_STW);
    assign mem_addr  = (state_q == S_MEM) ? a_q[AW-1:0] : pc_q;
    assign mem_wdata = b_q;
    assign halted    = (state_q == S_HALT);
    assign illegal   = illegal_q;

endmodule

// File: doc/cpu_core_p.md
CPU_CORE_P -- requirements
Module: cpu_core_p

Interface
REQ-001 Parameter DW, default 16: data/register width; legal values 16 to 64.
REQ-002 Parameter AW, default 16: word-address width; legal values AW <= DW.
REQ-003 Parameter RESET_PC, default 0: PC value loaded by reset.
REQ-004 Port CLK  in  1: single clock; all state changes on its rising edge.
REQ-005 Port reset  in  1: asynchronous, active-low; low forces reset state immediately.
REQ-006 Port mem_req  out  1: memory access request; held high until acknowledged.
REQ-007 Port mem_we  out  1: 1 = write, 0 = read; valid while mem_req is high.
REQ-008 Port mem_addr  out  AW: word address; valid while mem_req is high.
REQ-009 Port mem_wdata  out  DW: store data; valid while mem_req and mem_we are high.
REQ-010 Port mem_rdata  in  DW: read data; sampled in the cycle mem_ack is high.
REQ-011 Port mem_ack  in  1: access complete; may rise in the same cycle as mem_req.
REQ-012 Port halted  out  1: core is in HALT.
REQ-013 Port illegal  out  1: sticky flag; an undefined opcode was executed.

Function
REQ-014 The core SHALL decode the instruction from mem_rdata[15:0] as follows: op=[15:11], rd=[10:8], ra=[7:5], rb=[4:2], imm5=[4:0].
REQ-015 The register file SHALL hold 8 registers of DW bits each, with 2 combinational read ports (ra, and rb or rd) and 1 write port; r0 SHALL be an ordinary register.
REQ-016 The FSM SHALL have exactly these states: FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-017 FETCH: drive mem_req=1, mem_we=0, mem_addr=PC; on mem_ack, load IR and set PC=PC+1 modulo 2^AW, then go to DECODE; otherwise stay in FETCH.
REQ-018 DECODE: latch the operands A=R[ra] and B (R[rb], or sign-extended imm5 for immediate ops), then go to EXEC.
REQ-019 Opcodes 0-6 (ADD, SUB, OR, AND, XOR, SL, SR) SHALL use A op R[rb]; opcodes 7-13 SHALL be the same seven operations on A op sext(imm5).
REQ-020 Arithmetic SHALL be modulo 2^DW; the shift amount SHALL be B[log2(DW)-1:0]; SR SHALL be a logical shift.
REQ-021 Opcodes 14/15/16 (GT, LT, EQ) SHALL write 1 to rd if the signed comparison A vs R[rb] holds, else 0.
REQ-022 ALU and compare ops SHALL go EXEC->WB; in WB, write the result to rd, update flag Z (result==0) and flag N (result[DW-1]), then go to FETCH.
REQ-023 Opcode 17 BR SHALL set PC=PC+sext(imm5) in EXEC and then go to FETCH.
REQ-024 Opcode 20 BZ SHALL branch as BR only if Z=1; opcode 21 BN SHALL branch only if N=1; when not taken, PC SHALL be unchanged; neither SHALL alter the flags.
REQ-025 Opcode 18 STW, in MEM: drive mem_req=1, mem_we=1, mem_addr=R[ra][AW-1:0], mem_wdata=R[rd]; on mem_ack go to FETCH.
REQ-026 Opcode 19 LDW, in MEM: drive mem_req=1, mem_we=0, mem_addr=R[ra][AW-1:0]; on mem_ack capture mem_rdata into the MDR and go to WB; WB writes the MDR to rd and SHALL NOT update the flags.
REQ-027 Opcode 22 HALT SHALL go to HALT; HALT is terminal until reset; halted=1 while in HALT.
REQ-028 Opcodes 23-31 SHALL set illegal=1 and go to HALT, with no register, flag or PC side effects beyond the fetch increment.
REQ-029 mem_addr, mem_we and mem_wdata SHALL be held stable while mem_req=1 and mem_ack=0; mem_req SHALL be 0 in DECODE, EXEC, WB and HALT.
REQ-030 Zero-wait-state latency (mem_ack in the same cycle as mem_req) SHALL be: ALU/compare 4 cycles, LDW 5, STW 4, BR/BZ/BN 3, HALT 3.
REQ-031 A write to rd and a read of the same register in the same cycle SHALL return the old value.

Reset
REQ-032 While reset=0, the core SHALL hold: state=FETCH, PC=RESET_PC, IR=0, MDR=0, all registers=0, Z=N=0, illegal=0, halted=0, mem_req=0, mem_we=0.
REQ-033 On release of reset, the first mem_req SHALL assert in the first cycle after the rising edge of CLK that follows reset deassertion.
REQ-034 Reset asserted mid-access (mem_req=1, no ack yet) SHALL drop mem_req immediately and discard the access; a late mem_ack SHALL be ignored.

Verification
REQ-035 Zero-wait program ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2; HALT -> r3=2, Z=0, N=0, halted after 15 cycles, PC=4.
REQ-036 DW=32 program: SUBI r1,r0,1; SRI r2,r1,31 -> r1=0xFFFFFFFF, N=1 after the first op; r2=1, N=0 after the second.
REQ-037 STW r5->[r4=0x10] with ack delayed 3 cycles -> mem_req held 4 cycles with addr/wdata stable; then LDW r6,[r4] -> r6=r5; flags unchanged.
REQ-038 SUB r1,r2,r2 then BZ -2 -> Z=1, taken, PC wraps to the SUB; BN with N=0 -> PC sequential.
REQ-039 Opcode 25 fetched -> illegal=1, halted=1, no further mem_req; assert reset=0 -> illegal=0, PC=RESET_PC.
REQ-040 Assert reset=0 during a waiting FETCH -> mem_req=0 in the same cycle; pulse mem_ack during reset -> no IR load.
